// File: rtl/combinational_alu.sv
// combinational_alu: unsigned add/sub/mul/div of two operands evaluated in
// parallel, with a single output register stage (1-cycle latency, full
// throughput). Division is an unrolled restoring divider.
module combinational_alu #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_value_a,
  input  logic [WIDTH-1:0] i_value_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_value_add,
  output logic [WIDTH-1:0] o_value_sub,
  output logic [WIDTH-1:0] o_value_mul,
  output logic [WIDTH-1:0] o_value_div,
  output logic             o_div_zero
);

  logic [WIDTH-1:0] add_d, sub_d, mul_d, div_d;
  logic             dz_d;

  logic [WIDTH-1:0] add_q, sub_q, mul_q, div_q;
  logic             dz_q;
  logic             vld_q;

  // Remainder carries one extra bit so the trial subtraction's sign is visible.
  logic [WIDTH:0]   rem;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo;

  // Wrapping add/sub and low half of the product; operand widths keep the
  // result at WIDTH bits so carry, borrow and the upper product are dropped.
  always_comb begin
    add_d = i_value_a + i_value_b;
    sub_d = i_value_a - i_value_b;
    mul_d = i_value_a * i_value_b;
  end

  // Restoring divider: one shift/trial-subtract/restore step per quotient
  // bit, MSB first. A zero divisor is forced to the all-ones quotient.
  always_comb begin
    rem   = '0;
    trial = '0;
    quo   = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      rem   = {rem[WIDTH-1:0], i_value_a[i]};
      trial = rem - {1'b0, i_value_b};
      if (!trial[WIDTH]) begin
        rem    = trial;
        quo[i] = 1'b1;
      end
    end
    dz_d  = (i_value_b == '0);
    div_d = dz_d ? {WIDTH{1'b1}} : quo;
  end

  // Output register: reset clears everything, capture on i_valid, else hold.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      vld_q <= 1'b0;
      add_q <= '0;
      sub_q <= '0;
      mul_q <= '0;
      div_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      vld_q <= i_valid;
      if (i_valid) begin
        add_q <= add_d;
        sub_q <= sub_d;
        mul_q <= mul_d;
        div_q <= div_d;
        dz_q  <= dz_d;
      end
    end
  end

  assign o_valid     = vld_q;
  assign o_value_add = add_q;
  assign o_value_sub = sub_q;
  assign o_value_mul = mul_q;
  assign o_value_div = div_q;
  assign o_div_zero  = dz_q;

endmodule

// File: tb/tb_combinational_alu.sv
// Testbench for combinational_alu: directed cases, corner-value grid,
// zero-divisor sweep and randomized traffic against an arithmetic model.
module tb_combinational_alu;
  localparam int W = 8;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         vld_in;
  logic [W-1:0] a, b;
  logic         vld_out, dz;
  logic [W-1:0] r_add, r_sub, r_mul, r_div;

  always #5 clk = ~clk;

  combinational_alu #(.WIDTH(W)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (vld_in),
    .i_value_a   (a),
    .i_value_b   (b),
    .o_valid     (vld_out),
    .o_value_add (r_add),
    .o_value_sub (r_sub),
    .o_value_mul (r_mul),
    .o_value_div (r_div),
    .o_div_zero  (dz)
  );

  int checks = 0;
  int errors = 0;

  // Expected registered outputs
  int e_vld, e_add, e_sub, e_mul, e_div, e_dz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then compare all outputs.
  task automatic step(input int av, input int bv, input bit v, input bit rst);
    rst_n  = ~rst;
    vld_in = v;
    a      = W'(av);
    b      = W'(bv);
    @(posedge clk);
    if (rst) begin
      e_vld = 0; e_add = 0; e_sub = 0; e_mul = 0; e_div = 0; e_dz = 0;
    end else if (v) begin
      e_vld = 1;
      e_add = (av + bv) % M;
      e_sub = (av - bv + M) % M;
      e_mul = (av * bv) % M;
      e_div = (bv == 0) ? (M - 1) : (av / bv);
      e_dz  = (bv == 0) ? 1 : 0;
    end else begin
      e_vld = 0;
    end
    #1;
    chk($sformatf("valid a=%0d b=%0d", av, bv), {31'b0, vld_out}, e_vld);
    chk($sformatf("add a=%0d b=%0d", av, bv),   {24'b0, r_add},   e_add);
    chk($sformatf("sub a=%0d b=%0d", av, bv),   {24'b0, r_sub},   e_sub);
    chk($sformatf("mul a=%0d b=%0d", av, bv),   {24'b0, r_mul},   e_mul);
    chk($sformatf("div a=%0d b=%0d", av, bv),   {24'b0, r_div},   e_div);
    chk($sformatf("dz a=%0d b=%0d", av, bv),    {31'b0, dz},      e_dz);
  endtask

  int corner [6] = '{0, 1, 127, 128, 254, 255};

  initial begin
    rst_n = 1'b0; vld_in = 1'b0; a = '0; b = '0;

    // Reset with valid asserted: outputs stay zero
    step(20, 10, 1'b1, 1'b1);
    step(20, 10, 1'b1, 1'b1);

    // Directed cases
    step(20, 10, 1'b1, 1'b0);
    step(200, 100, 1'b1, 1'b0);
    step(10, 20, 1'b1, 1'b0);
    step(37, 0, 1'b1, 1'b0);

    // Hold with valid low, then reset clears held results
    step(99, 3, 1'b0, 1'b0);
    step(5, 5, 1'b0, 1'b0);
    step(5, 5, 1'b1, 1'b1);
    step(77, 7, 1'b1, 1'b0);

    // Corner-value grid, back to back
    for (int i = 0; i < 6; i++)
      for (int j = 0; j < 6; j++)
        step(corner[i], corner[j], 1'b1, 1'b0);

    // Every dividend against a zero divisor, and against divisor 1
    for (int i = 0; i < M; i++) step(i, 0, 1'b1, 1'b0);
    for (int i = 0; i < M; i++) step(i, 1, 1'b1, 1'b0);

    // Randomized traffic with occasional idle cycles, zero divisors and resets
    for (int n = 0; n < 3000; n++) begin
      int  av, bv;
      bit  v, r;
      av = int'($urandom_range(0, M - 1));
      bv = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, M - 1));
      v  = ($urandom_range(0, 4) != 0);
      r  = ($urandom_range(0, 99) == 0);
      step(av, bv, v, r);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
